// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared stage indices, widths, FSM states and the stall
//                resolution helper for the pipeline stall/flush sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  // Pipeline register indexing: pc, if_id, id_ex, ex_mem, mem_wb
  localparam int STAGE_N   = 5;
  localparam int REQ_N     = 4;
  localparam int IF_ID_IDX = 1;
  localparam int ID_EX_IDX = 2;

  // Commit-time events bubble every register after pc
  localparam logic [STAGE_N-1:0] COMMIT_FLUSH = 5'b11110;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } redir_state_e;

  typedef struct packed {
    logic [STAGE_N-1:0] stall;
    logic [STAGE_N-1:0] flush;
  } hold_t;

  // Highest requesting stage s holds registers [s:0] and bubbles s+1
  function automatic hold_t resolve_stall(input logic [REQ_N-1:0] req);
    hold_t r;
    r = '0;
    casez (req)
      4'b1???: begin r.stall = 5'b01111; r.flush = 5'b10000; end
      4'b01??: begin r.stall = 5'b00111; r.flush = 5'b01000; end
      4'b001?: begin r.stall = 5'b00011; r.flush = 5'b00100; end
      4'b0001: begin r.stall = 5'b00001; r.flush = 5'b00010; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_watchdog.sv
// ============================================================================
//  Module      : pipe_stall_watchdog
//  Description : Counts consecutive stalled cycles (saturating) and raises a
//                sticky timeout flag when the count reaches STALL_TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_watchdog #(
  parameter int STALL_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any,
  output logic timeout
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Next count: clear on any unstalled cycle, otherwise step up to the ceiling
  always_comb begin
    cnt_next = '0;
    if (stall_any) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
  end

  // Counter and sticky flag; only reset clears the flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (stall_any && (cnt_next == CNT_MAX)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. Resolves
//                stage stall requests, EX branch redirects and commit-time
//                exception/ertn into per-register stall/flush vectors and a
//                registered PC-redirect handshake toward IF. Includes a stall
//                watchdog. Optional PIPE_CTRL_PERF_EN adds perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1023,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        stallreq_i,
  input  logic              branch_flush_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              excp_i,
  input  logic [ADDR_W-1:0] excp_entry_i,
  input  logic              ertn_i,
  input  logic [ADDR_W-1:0] era_i,
  input  logic              redirect_ready_i,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic              excp_flush_o,
  output logic              ertn_flush_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o
`endif
);

  redir_state_e      state;
  redir_state_e      state_next;
  hold_t             hold;
  logic              excp_take;
  logic              ertn_take;
  logic              br_take;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;

  // Raw stall resolution from the request vector
  always_comb hold = resolve_stall(stallreq_i);

  // Event arbitration, stall/flush vectors and redirect FSM next state
  always_comb begin
    state_next   = state;
    stall_o      = '0;
    flush_o      = '0;
    excp_flush_o = 1'b0;
    ertn_flush_o = 1'b0;
    excp_take    = 1'b0;
    ertn_take    = 1'b0;
    br_take      = 1'b0;
    pc_load      = 1'b0;
    pc_next      = redirect_pc_o;
    if (!rst) begin
      excp_take = excp_i;
      ertn_take = ertn_i & ~excp_i;
      // A branch needs EX to advance, and a pending redirect already owns IF
      br_take   = branch_flush_i & ~excp_i & ~ertn_i
                & ~hold.stall[ID_EX_IDX] & (state == ST_IDLE);

      if (excp_take || ertn_take) begin
        flush_o = COMMIT_FLUSH;
      end else begin
        stall_o = hold.stall;
        flush_o = hold.flush;
        if (br_take) begin
          flush_o[ID_EX_IDX:IF_ID_IDX] = 2'b11;
        end
        // Whatever IF fetches while the redirect is pending is wrong-path
        if (state == ST_REDIR) begin
          flush_o[IF_ID_IDX] = 1'b1;
        end
      end

      excp_flush_o = excp_take;
      ertn_flush_o = ertn_take;
      pc_load      = excp_take | ertn_take | br_take;

      if (excp_take) begin
        pc_next = excp_entry_i;
      end else if (ertn_take) begin
        pc_next = era_i;
      end else if (br_take) begin
        pc_next = branch_target_i;
      end

      if (pc_load) begin
        state_next = ST_REDIR;
      end else if ((state == ST_REDIR) && redirect_ready_i) begin
        state_next = ST_IDLE;
      end
    end
  end

  // Redirect FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Redirect target register, loaded only when an event is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_o <= '0;
    end else if (pc_load) begin
      redirect_pc_o <= pc_next;
    end
  end

  assign redirect_valid_o = (state == ST_REDIR);

  pipe_stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .stall_any (|stall_o),
    .timeout   (stall_timeout_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  // Free-running wrapping counters of stalled cycles and accepted redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (|stall_o) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if (pc_load) begin
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    stallreq = '0;
  logic          br = 1'b0;
  logic [AW-1:0] btgt = '0;
  logic          excp = 1'b0;
  logic [AW-1:0] entry = '0;
  logic          ertn = 1'b0;
  logic [AW-1:0] era = '0;
  logic          ready = 1'b0;
  logic [4:0]    stall_o;
  logic [4:0]    flush_o;
  logic          excp_flush_o;
  logic          ertn_flush_o;
  logic          valid_o;
  logic [AW-1:0] pc_o;
  logic          timeout_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit            m_pend = 1'b0;
  logic [AW-1:0] m_tgt  = '0;
  int            m_cnt  = 0;
  bit            m_to   = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STALL_TIMEOUT (TO),
    .ADDR_W        (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_i       (stallreq),
    .branch_flush_i   (br),
    .branch_target_i  (btgt),
    .excp_i           (excp),
    .excp_entry_i     (entry),
    .ertn_i           (ertn),
    .era_i            (era),
    .redirect_ready_i (ready),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .excp_flush_o     (excp_flush_o),
    .ertn_flush_o     (ertn_flush_o),
    .redirect_valid_o (valid_o),
    .redirect_pc_o    (pc_o),
    .stall_timeout_o  (timeout_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin : cmp
    logic [4:0] es;
    logic [4:0] ef;
    int  hi;
    bit  ev_x, ev_e, ev_b;
    if (rst) begin
      chk("m_rst_stall",   stall_o, 0);
      chk("m_rst_flush",   flush_o, 0);
      chk("m_rst_valid",   valid_o, 0);
      chk("m_rst_pc",      pc_o, 0);
      chk("m_rst_timeout", timeout_o, 0);
      m_pend = 1'b0; m_tgt = '0; m_cnt = 0; m_to = 1'b0;
    end else begin
      hi = -1;
      for (int i = 0; i < 4; i++) if (stallreq[i]) hi = i;
      ev_x = excp;
      ev_e = ertn && !excp;
      ev_b = br && !excp && !ertn && !m_pend && (hi < 2);
      if (ev_x || ev_e) begin
        es = 5'b0;
        ef = 5'b11110;
      end else begin
        es = (hi < 0) ? 5'b0 : 5'((1 << (hi + 1)) - 1);
        ef = (hi < 0) ? 5'b0 : 5'(1 << (hi + 1));
        if (ev_b)   ef = ef | 5'b00110;
        if (m_pend) ef = ef | 5'b00010;
      end
      chk("m_stall",      stall_o, es);
      chk("m_flush",      flush_o, ef);
      chk("m_excp_flush", excp_flush_o, ev_x);
      chk("m_ertn_flush", ertn_flush_o, ev_e);
      chk("m_valid",      valid_o, m_pend);
      if (m_pend) chk("m_pc", pc_o, m_tgt);
      chk("m_timeout",    timeout_o, m_to);

      if (es != 0) begin
        if (m_cnt < TO) m_cnt++;
        if (m_cnt == TO) m_to = 1'b1;
      end else begin
        m_cnt = 0;
      end
      if (ev_x)                begin m_pend = 1'b1; m_tgt = entry; end
      else if (ev_e)           begin m_pend = 1'b1; m_tgt = era;   end
      else if (ev_b)           begin m_pend = 1'b1; m_tgt = btgt;  end
      else if (m_pend && ready) m_pend = 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_stall", stall_o, 0);
    next_cycle();
    rst = 1'b0;

    // Stall resolution
    stallreq = 4'b0100;
    @(negedge clk);
    chk("stall_ex_stall", stall_o, 5'b00111);
    chk("stall_ex_flush", flush_o, 5'b01000);
    next_cycle();
    stallreq = 4'b1001;
    @(negedge clk);
    chk("stall_mem_stall", stall_o, 5'b01111);
    chk("stall_mem_flush", flush_o, 5'b10000);

    // Branch redirect held while IF is not ready
    next_cycle();
    stallreq = 4'b0000; br = 1'b1; btgt = 32'h1c000100; ready = 1'b0;
    @(negedge clk);
    chk("br_flush", flush_o, 5'b00110);
    next_cycle();
    br = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("br_hold_valid", valid_o, 1);
      chk("br_hold_pc", pc_o, 32'h1c000100);
      chk("br_hold_flush", flush_o, 5'b00010);
      next_cycle();
    end
    ready = 1'b1;
    @(negedge clk);
    chk("br_ready_valid", valid_o, 1);
    next_cycle();
    ready = 1'b0;
    @(negedge clk);
    chk("br_idle_valid", valid_o, 0);

    // Branch blocked by an EX stall
    next_cycle();
    stallreq = 4'b0100; br = 1'b1; btgt = 32'h1c000180;
    @(negedge clk);
    chk("br_stalled_flush", flush_o, 5'b01000);
    next_cycle();
    stallreq = 4'b0000; br = 1'b0;
    @(negedge clk);
    chk("br_stalled_noredir", valid_o, 0);

    // Exception and ertn together under a MEM stall
    next_cycle();
    stallreq = 4'b1000; excp = 1'b1; ertn = 1'b1;
    entry = 32'h1c008000; era = 32'h1c000240;
    @(negedge clk);
    chk("excp_stall", stall_o, 5'b00000);
    chk("excp_flush", flush_o, 5'b11110);
    chk("excp_pulse", excp_flush_o, 1);
    chk("excp_ertn_pulse", ertn_flush_o, 0);
    next_cycle();
    stallreq = 4'b0000; excp = 1'b0; ertn = 1'b0; ready = 1'b1;
    @(negedge clk);
    chk("excp_redir_valid", valid_o, 1);
    chk("excp_redir_pc", pc_o, 32'h1c008000);
    next_cycle();
    ready = 1'b0;

    // Pending branch overridden by ertn
    br = 1'b1; btgt = 32'h1c000300;
    next_cycle();
    br = 1'b0; ertn = 1'b1; era = 32'h1c000200;
    @(negedge clk);
    chk("ovr_pend_pc", pc_o, 32'h1c000300);
    chk("ovr_ertn_pulse", ertn_flush_o, 1);
    next_cycle();
    ertn = 1'b0;
    @(negedge clk);
    chk("ovr_valid", valid_o, 1);
    chk("ovr_pc", pc_o, 32'h1c000200);
    next_cycle();
    ready = 1'b1;
    next_cycle();

    // Randomized traffic checked by the model
    for (int n = 0; n < 1500; n++) begin
      stallreq = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'b0;
      br       = ($urandom_range(0, 3) == 0);
      btgt     = $urandom;
      excp     = ($urandom_range(0, 11) == 0);
      entry    = $urandom;
      ertn     = ($urandom_range(0, 9) == 0);
      era      = $urandom;
      ready    = $urandom_range(0, 1);
      next_cycle();
    end

    // Fresh reset before the watchdog scenario
    stallreq = '0; br = 1'b0; excp = 1'b0; ertn = 1'b0; ready = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Watchdog trips after STALL_TIMEOUT stalled cycles and stays set
    stallreq = 4'b0001;
    for (int i = 0; i < 7; i++) @(posedge clk);
    @(negedge clk);
    chk("wd_before", timeout_o, 0);
    next_cycle();
    stallreq = 4'b0000;
    @(negedge clk);
    chk("wd_trip", timeout_o, 1);
    repeat (3) next_cycle();
    chk("wd_sticky", timeout_o, 1);

    // Reset in the middle of a redirect
    br = 1'b1; btgt = 32'h1c000400;
    next_cycle();
    br = 1'b0;
    @(negedge clk);
    chk("rr_valid", valid_o, 1);
    next_cycle();
    rst = 1'b1; stallreq = 4'b1000;
    @(negedge clk);
    chk("rr_valid_drop", valid_o, 0);
    chk("rr_stall", stall_o, 0);
    chk("rr_flush", flush_o, 0);
    chk("rr_timeout", timeout_o, 0);
    next_cycle();
    rst = 1'b0; stallreq = 4'b0000;
    @(negedge clk);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
